mem_req_rsp: RTL

Parametrised single-port synchronous memory with a request/response handshake. It supports byte-strobed writes, an in-order response stream with backpressure, an automatic post-reset clear sequence, and out-of-range address reporting. It sits between a bus master or controller and local storage. It replaces the simple valid/ready memory, whose read data had no way to stall.

---
 rtl/mem_req_rsp_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/mem_req_rsp.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_req_rsp_pkg.sv
// Shared types and helpers for the request/response memory.
package mem_req_rsp_pkg;

  // Controller states: walk-and-zero the array, then serve requests.
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // One byte enable per 8 data bits.
  function automatic int strb_width(input int width);
    return width / 8;
  endfunction

  // Response buffer entry is {err, rdata}: error flag in the MSB above the data word.
  function automatic int rsp_entry_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; used as the response buffer.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = store[rd_ptr];

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_req_rsp.sv
// Single-port memory with request/response handshake, post-reset clear
// and out-of-range reporting.
module mem_req_rsp
  import mem_req_rsp_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int RSP_DEPTH  = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int STRB_WIDTH = strb_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int ENTRY_W = rsp_entry_width(WIDTH);
  localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W:0]        RSP_LIMIT = (CNT_W + 1)'(RSP_DEPTH);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  pipe_valid;
  logic                  pipe_err;
  logic [WIDTH-1:0]      pipe_rdata;
  logic                  accept;
  logic                  in_range;

  logic [ENTRY_W-1:0]    buf_din;
  logic [ENTRY_W-1:0]    buf_dout;
  logic [CNT_W-1:0]      buf_count;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  buf_pop;

  // State and clear-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Step the clear address each cycle; leave CLEAR after zeroing the last word.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == ST_CLEAR) begin
      clr_addr_nxt = clr_addr + 1'b1;
      if (clr_addr == LAST_ADDR) begin
        state_nxt    = ST_RUN;
        clr_addr_nxt = '0;
      end
    end
  end

  // Reserve a buffer slot for every request in flight so the pipeline never stalls.
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
  assign req_ready = (state == ST_RUN) && !buf_full &&
                     (({1'b0, buf_count} + (CNT_W + 1)'(pipe_valid)) < RSP_LIMIT);
  assign accept    = req_valid && req_ready;
  assign init_done = (state == ST_RUN);

  // Storage: clear walk, or byte-strobed write for in-range accepted writes.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (!rst && accept && req_wr && in_range) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (req_strb[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Pipeline stage: synchronous read and error flag, pushed to the buffer next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_err   <= 1'b0;
      pipe_rdata <= '0;
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        pipe_err   <= !in_range;
        pipe_rdata <= (!req_wr && in_range) ? mem[req_addr] : '0;
      end
    end
  end

  assign buf_din = {pipe_err, pipe_rdata};
  assign buf_pop = rsp_ready && !buf_empty;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_valid),
    .pop   (buf_pop),
    .din   (buf_din),
    .dout  (buf_dout),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  assign rsp_valid = !buf_empty;
  assign rsp_rdata = buf_empty ? '0 : buf_dout[WIDTH-1:0];
  assign rsp_err   = !buf_empty && buf_dout[WIDTH];

endmodule
